// File: rtl/word_reducer_stream_if.sv
// Handshake bundle for word_reducer_stream: beat input side and reduced-result output side.
// master drives beats and consumes results; slave is the reducer.
interface word_reducer_stream_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int COUNT_WIDTH = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic [WORD_WIDTH*LANES-1:0] in_words;
  logic [LANES-1:0]            in_lane_enable;
  logic                        in_last;
  logic [2:0]                  in_op;
  logic                        out_valid;
  logic                        out_ready;
  logic [WORD_WIDTH-1:0]       out_word;
  logic [COUNT_WIDTH-1:0]      out_count;
  logic                        out_overflow;

  modport master (
    output in_valid, in_words, in_lane_enable, in_last, in_op, out_ready,
    input  in_ready, out_valid, out_word, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_words, in_lane_enable, in_last, in_op, out_ready,
    output in_ready, out_valid, out_word, out_count, out_overflow
  );
endinterface

// File: rtl/word_reducer_stream.sv
// Folds a frame of multi-lane words into one AND/OR/XOR (optionally inverted) word,
// with a saturating count of the enabled words seen in the frame.
module word_reducer_stream #(
  parameter int WORD_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int COUNT_WIDTH = 16
) (
  input logic                  clock,
  input logic                  reset,
  word_reducer_stream_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

  state_t                 state;
  logic [2:0]             op_reg;
  logic [WORD_WIDTH-1:0]  acc_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   overflow_reg;
  logic                   in_ready_reg;
  logic                   out_valid_reg;
  logic [WORD_WIDTH-1:0]  out_word_reg;
  logic [COUNT_WIDTH-1:0] out_count_reg;
  logic                   out_overflow_reg;

  logic                   accept;
  logic [2:0]             op_sel;
  logic [WORD_WIDTH-1:0]  identity;
  logic [WORD_WIDTH-1:0]  acc_base;
  logic [WORD_WIDTH-1:0]  acc_next;
  logic [WORD_WIDTH-1:0]  result_word;
  logic [WORD_WIDTH-1:0]  lane_word [LANES];
  logic [COUNT_WIDTH:0]   pop;
  logic [COUNT_WIDTH:0]   sum;
  logic [COUNT_WIDTH-1:0] count_base;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   overflow_next;

  assign accept = bus.in_valid && in_ready_reg;

  // The first beat of a frame uses the live opcode and a fresh identity seed.
  assign op_sel     = (state == IDLE) ? bus.in_op : op_reg;
  assign identity   = (op_sel[1:0] == 2'd0) ? {WORD_WIDTH{1'b1}} : {WORD_WIDTH{1'b0}};
  assign acc_base   = (state == IDLE) ? identity : acc_reg;
  assign count_base = (state == IDLE) ? {COUNT_WIDTH{1'b0}} : count_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_word[gi] = bus.in_lane_enable[gi] ? bus.in_words[WORD_WIDTH*gi +: WORD_WIDTH]
                                                    : identity;
    end
  endgenerate

  always_comb begin
    acc_next = acc_base;
    pop      = '0;
    for (int i = 0; i < LANES; i++) begin
      case (op_sel[1:0])
        2'd0:    acc_next = acc_next & lane_word[i];
        2'd1:    acc_next = acc_next | lane_word[i];
        default: acc_next = acc_next ^ lane_word[i];
      endcase
      pop = pop + {{COUNT_WIDTH{1'b0}}, bus.in_lane_enable[i]};
    end
  end

  assign sum         = {1'b0, count_base} + pop;
  assign result_word = op_sel[2] ? ~acc_next : acc_next;

  always_comb begin
    count_next    = sum[COUNT_WIDTH-1:0];
    overflow_next = (state == IDLE) ? 1'b0 : overflow_reg;
    if (sum[COUNT_WIDTH]) begin
      count_next    = {COUNT_WIDTH{1'b1}};
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      op_reg           <= '0;
      acc_reg          <= '0;
      count_reg        <= '0;
      overflow_reg     <= 1'b0;
      in_ready_reg     <= 1'b0;
      out_valid_reg    <= 1'b0;
      out_word_reg     <= '0;
      out_count_reg    <= '0;
      out_overflow_reg <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          in_ready_reg <= 1'b1;
          if (accept) begin
            acc_reg      <= acc_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            if (state == IDLE) op_reg <= bus.in_op;
            if (bus.in_last) begin
              state            <= DONE;
              in_ready_reg     <= 1'b0;
              out_valid_reg    <= 1'b1;
              out_word_reg     <= result_word;
              out_count_reg    <= count_next;
              out_overflow_reg <= overflow_next;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.out_word     = out_word_reg;
  assign bus.out_count    = out_count_reg;
  assign bus.out_overflow = out_overflow_reg;

endmodule

// File: tb/tb_word_reducer_stream.sv
// Scoreboard bench for word_reducer_stream: a default instance and a 4-bit-counter
// instance for saturation; expected results queue up as frames are driven.
module tb_word_reducer_stream;

  logic clk;
  logic rst;

  word_reducer_stream_if #(.WORD_WIDTH(8), .LANES(4), .COUNT_WIDTH(16)) a_if ();
  word_reducer_stream_if #(.WORD_WIDTH(8), .LANES(4), .COUNT_WIDTH(4))  b_if ();

  word_reducer_stream #(.WORD_WIDTH(8), .LANES(4), .COUNT_WIDTH(16)) dut_a (
    .clock(clk), .reset(rst), .bus(a_if.slave));
  word_reducer_stream #(.WORD_WIDTH(8), .LANES(4), .COUNT_WIDTH(4)) dut_b (
    .clock(clk), .reset(rst), .bus(b_if.slave));

  typedef struct packed {
    logic [7:0]  w;
    logic [15:0] c;
    logic        ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int n_pushed     = 0;
  int n_seen       = 0;

  logic [7:0] m_acc   [2];
  int         m_cnt   [2];
  bit         m_ovf   [2];
  logic [2:0] m_op    [2];
  bit         m_first [2];
  int         m_max   [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, obs);
    end
  endtask

  // Updates the reference model for one beat, drives it, and waits for acceptance.
  task automatic send_beat(input int sel, input logic [31:0] words, input logic [3:0] en,
                           input logic last, input logic [2:0] op, output int waited);
    bit   ok;
    exp_t e;
    logic [7:0] w;
    ok     = 1'b0;
    waited = 0;
    if (m_first[sel]) begin
      m_op[sel]    = op;
      m_acc[sel]   = (op[1:0] == 2'd0) ? 8'hFF : 8'h00;
      m_cnt[sel]   = 0;
      m_ovf[sel]   = 1'b0;
      m_first[sel] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        w = words[8*i +: 8];
        case (m_op[sel][1:0])
          2'd0:    m_acc[sel] = m_acc[sel] & w;
          2'd1:    m_acc[sel] = m_acc[sel] | w;
          default: m_acc[sel] = m_acc[sel] ^ w;
        endcase
        if (m_cnt[sel] == m_max[sel]) m_ovf[sel] = 1'b1;
        else m_cnt[sel] = m_cnt[sel] + 1;
      end
    end
    if (sel == 0) begin
      a_if.in_valid = 1'b1; a_if.in_words = words; a_if.in_lane_enable = en;
      a_if.in_last = last; a_if.in_op = op;
    end else begin
      b_if.in_valid = 1'b1; b_if.in_words = words; b_if.in_lane_enable = en;
      b_if.in_last = last; b_if.in_op = op;
    end
    while (!ok && waited < 100) begin
      @(negedge clk);
      if ((sel == 0) ? a_if.in_ready : b_if.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    a_if.in_valid = 1'b0;
    b_if.in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    if (last) begin
      e.w   = m_op[sel][2] ? ~m_acc[sel] : m_acc[sel];
      e.c   = 16'(m_cnt[sel]);
      e.ovf = m_ovf[sel];
      if (sel == 0) qa.push_back(e);
      else qb.push_back(e);
      n_pushed++;
      m_first[sel] = 1'b1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0) check("drain_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_if.out_valid && a_if.out_ready) begin
      n_seen++;
      if (qa.size() == 0) check("a_unexpected_out", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        check("a_out_word", {24'd0, a_if.out_word}, {24'd0, e.w});
        check("a_out_count", {16'd0, a_if.out_count}, {16'd0, e.c});
        check("a_out_overflow", {31'd0, a_if.out_overflow}, {31'd0, e.ovf});
      end
    end
    if (!rst && b_if.out_valid && b_if.out_ready) begin
      n_seen++;
      if (qb.size() == 0) check("b_unexpected_out", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        check("b_out_word", {24'd0, b_if.out_word}, {24'd0, e.w});
        check("b_out_count", {28'd0, b_if.out_count}, {16'd0, e.c});
        check("b_out_overflow", {31'd0, b_if.out_overflow}, {31'd0, e.ovf});
      end
    end
  end

  initial begin
    int waited;
    m_max[0] = 65535; m_max[1] = 15;
    m_first[0] = 1'b1; m_first[1] = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_words = '0; a_if.in_lane_enable = '0;
    a_if.in_last = 1'b0; a_if.in_op = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_words = '0; b_if.in_lane_enable = '0;
    b_if.in_last = 1'b0; b_if.in_op = '0; b_if.out_ready = 1'b1;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, a_if.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, a_if.out_valid}, 32'd0);
    check("rst_out_word", {24'd0, a_if.out_word}, 32'd0);
    check("rst_out_count", {16'd0, a_if.out_count}, 32'd0);
    check("rst_out_overflow", {31'd0, a_if.out_overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_before_edge", {31'd0, a_if.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("in_ready_after_edge", {31'd0, a_if.in_ready}, 32'd1);

    // Single AND beat with the output held back, then back-pressure on the next frame.
    send_beat(0, {8'hF0, 8'hFF, 8'hF3, 8'hF1}, 4'hF, 1'b1, 3'd0, waited);
    check("single_out_valid_latency", {31'd0, a_if.out_valid}, 32'd1);
    check("single_in_ready_low", {31'd0, a_if.in_ready}, 32'd0);
    a_if.in_valid = 1'b1; a_if.in_words = {8'h08, 8'h04, 8'h02, 8'h01};
    a_if.in_lane_enable = 4'hF; a_if.in_last = 1'b0; a_if.in_op = 3'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, a_if.in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, a_if.out_valid}, 32'd1);
      check("bp_out_word", {24'd0, a_if.out_word}, 32'h0000_00F0);
      check("bp_out_count", {16'd0, a_if.out_count}, 32'd4);
    end
    @(posedge clk);
    #1;
    a_if.out_ready = 1'b1;

    // Three-beat XNOR; the opcode on later beats must be ignored.
    send_beat(0, {8'h08, 8'h04, 8'h02, 8'h01}, 4'hF, 1'b0, 3'd6, waited);
    check("bp_accept_after_handshake", waited, 32'd2);
    send_beat(0, {8'h08, 8'h04, 8'h02, 8'h01}, 4'hF, 1'b0, 3'd0, waited);
    send_beat(0, {8'h08, 8'h04, 8'h02, 8'h01}, 4'hF, 1'b1, 3'd1, waited);
    check("xnor_out_valid_latency", {31'd0, a_if.out_valid}, 32'd1);

    // Lane masking, then an all-disabled NAND frame.
    send_beat(0, {8'h80, 8'h40, 8'h20, 8'h01}, 4'b0101, 1'b1, 3'd1, waited);
    send_beat(0, {8'h12, 8'h34, 8'h56, 8'h78}, 4'b0000, 1'b1, 3'd4, waited);
    drain();

    // Random frames across all opcodes.
    for (int f = 0; f < 6; f++) begin
      int nb;
      logic [2:0] op;
      nb = $urandom_range(1, 4);
      op = 3'($urandom_range(0, 7));
      for (int b = 0; b < nb; b++)
        send_beat(0, $urandom, 4'($urandom_range(0, 15)), (b == nb - 1), op, waited);
    end
    drain();

    // Saturation on the 4-bit counter instance, then a clean frame.
    for (int b = 0; b < 5; b++)
      send_beat(1, {8'h11, 8'h22, 8'h44, 8'h88}, 4'hF, (b == 4), 3'd2, waited);
    send_beat(1, {8'hAA, 8'h55, 8'h0F, 8'hF0}, 4'hF, 1'b1, 3'd1, waited);
    drain();

    // Mid-frame asynchronous reset after a frame left a nonzero result registered.
    send_beat(0, {8'h5A, 8'h5A, 8'h5A, 8'h5A}, 4'hF, 1'b1, 3'd1, waited);
    drain();
    send_beat(0, {8'h01, 8'h02, 8'h04, 8'h08}, 4'hF, 1'b0, 3'd1, waited);
    send_beat(0, {8'h10, 8'h20, 8'h40, 8'h80}, 4'hF, 1'b0, 3'd1, waited);
    #2;
    rst = 1'b1;
    m_first[0] = 1'b1;
    #1;
    check("midrst_out_word", {24'd0, a_if.out_word}, 32'd0);
    check("midrst_out_count", {16'd0, a_if.out_count}, 32'd0);
    check("midrst_in_ready", {31'd0, a_if.in_ready}, 32'd0);
    check("midrst_out_valid", {31'd0, a_if.out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_beat(0, {8'h3C, 8'hFF, 8'hFF, 8'hFF}, 4'hF, 1'b1, 3'd0, waited);
    drain();

    repeat (3) @(posedge clk);
    check("frames_seen", n_seen, n_pushed);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
